// File: rtl/tdm_pkg.sv
// Shared constants for the tdm_demux_14 receive path: FSM encoding, slot
// indices and a constant-sizing helper.
package tdm_pkg;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((int'(1) << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_shreg.sv
// One slot's MSB-first collection register. q_nxt exposes the value after
// the current bit so the final beat can be captured on the same edge.
module tdm_slot_shreg #(
  parameter int SLOT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [SLOT_W-1:0] q,
  output logic [SLOT_W-1:0] q_nxt
);

  logic [SLOT_W-1:0] sh_q, sh_d;

  always_comb begin
    q_nxt = (sh_q << 1) | SLOT_W'(din);
    sh_d  = sh_q;
    if (clr)     sh_d = '0;
    else if (en) sh_d = q_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign q = sh_q;

endmodule

// File: rtl/tdm_demux_14.sv
// 1-to-4 TDM demultiplexer: serial frames of four SLOT_W-bit slots are
// collected and presented in parallel, with HUNT/LOCK frame alignment.
module tdm_demux_14
  import tdm_pkg::*;
#(
  parameter int SLOT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              in_valid,
  input  logic              frame_sync,
  output logic [SLOT_W-1:0] a,
  output logic [SLOT_W-1:0] b,
  output logic [SLOT_W-1:0] c,
  output logic [SLOT_W-1:0] d,
  output logic              s0,
  output logic              s1,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  localparam int FRAME_BEATS = 4 * SLOT_W;
  localparam int CW = clog2(FRAME_BEATS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] SW   = CW'(SLOT_W);

  logic [0:0]              state_q, state_d;
  logic                    miss_q, miss_d;
  logic [CW-1:0]           beat_q, beat_d, eff_beat;
  logic                    frame_valid_q, frame_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic [3:0][SLOT_W-1:0]  out_q, out_d;
  logic [3:0][SLOT_W-1:0]  sh_q, sh_nxt;
  logic [1:0]              eff_slot, cur_slot;
  logic                    take, drop;

  // eff_beat is the frame position the incoming bit is taken as; a misaligned
  // sync restarts the frame, so it can differ from beat_q.
  always_comb begin
    state_d       = state_q;
    miss_d        = miss_q;
    beat_d        = beat_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    take          = 1'b0;
    drop          = 1'b0;
    eff_beat      = beat_q;
    if (in_valid) begin
      if (state_q == ST_HUNT) begin
        if (frame_sync) begin
          state_d  = ST_LOCK;
          miss_d   = 1'b0;
          take     = 1'b1;
          eff_beat = '0;
        end
      end else if (beat_q == '0) begin
        if (frame_sync) begin
          miss_d = 1'b0;
          take   = 1'b1;
        end else if (miss_q) begin
          state_d = ST_HUNT;
          miss_d  = 1'b0;
          drop    = 1'b1;
        end else begin
          miss_d = 1'b1;
          take   = 1'b1;
        end
      end else if (frame_sync) begin
        sync_err_d = 1'b1;
        miss_d     = 1'b0;
        take       = 1'b1;
        eff_beat   = '0;
      end else begin
        take = 1'b1;
      end
      if (take) begin
        if (eff_beat == LAST) begin
          beat_d        = '0;
          frame_valid_d = 1'b1;
          out_d         = {sh_nxt[3], sh_q[2], sh_q[1], sh_q[0]};
        end else begin
          beat_d = eff_beat + CW'(1);
        end
      end
    end
  end

  assign eff_slot = 2'(eff_beat / SW);
  assign cur_slot = 2'(beat_q / SW);

  for (genvar i = 0; i < 4; i++) begin : g_slot
    tdm_slot_shreg #(.SLOT_W(SLOT_W)) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .en    (take && (eff_slot == 2'(i))),
      .clr   (drop),
      .din   (din),
      .q     (sh_q[i]),
      .q_nxt (sh_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      miss_q        <= 1'b0;
      beat_q        <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_q        <= miss_d;
      beat_q        <= beat_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign a           = out_q[SLOT_A];
  assign b           = out_q[SLOT_B];
  assign c           = out_q[SLOT_C];
  assign d           = out_q[SLOT_D];
  assign {s1, s0}    = cur_slot;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == ST_LOCK);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_14.sv
// Directed bench for tdm_demux_14 at SLOT_W=1 and SLOT_W=4, checked each
// cycle against a frame-level model plus hand-computed expectations.
module tb_tdm_demux_14;

  logic clk = 1'b0, rst = 1'b1, din = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
  always #5 clk = ~clk;

  logic       a1, b1, c1, d1, s0_1, s1_1, fv1, lk1, se1;
  logic [3:0] a4, b4, c4, d4;
  logic       s0_4, s1_4, fv4, lk4, se4;

  tdm_demux_14 #(.SLOT_W(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .frame_sync(frame_sync),
    .a(a1), .b(b1), .c(c1), .d(d1), .s0(s0_1), .s1(s1_1),
    .frame_valid(fv1), .locked(lk1), .sync_err(se1));

  tdm_demux_14 #(.SLOT_W(4)) u4 (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .frame_sync(frame_sync),
    .a(a4), .b(b4), .c(c4), .d(d4), .s0(s0_4), .s1(s1_4),
    .frame_valid(fv4), .locked(lk4), .sync_err(se4));

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: bits of the frame in progress accumulate into an
  // integer; slots are sliced out arithmetically when the frame completes.
  int              mw[2] = '{1, 4};
  bit              mlk[2], mmiss[2], mfv[2], mse[2];
  int              mpos[2];
  longint unsigned mval[2];
  int              ma[2], mb[2], mc[2], md[2];

  function automatic void mstep(input int k);
    bit tk;
    int w, msk;
    w   = mw[k];
    msk = (1 << w) - 1;
    if (rst) begin
      mlk[k] = 0; mmiss[k] = 0; mpos[k] = 0; mval[k] = 0;
      ma[k] = 0; mb[k] = 0; mc[k] = 0; md[k] = 0;
      mfv[k] = 0; mse[k] = 0;
      return;
    end
    mfv[k] = 0; mse[k] = 0;
    if (!in_valid) return;
    tk = 0;
    if (!mlk[k]) begin
      if (frame_sync) begin mlk[k] = 1; mmiss[k] = 0; mpos[k] = 0; mval[k] = 0; tk = 1; end
    end else if (mpos[k] == 0) begin
      if (frame_sync) begin mmiss[k] = 0; tk = 1; end
      else if (mmiss[k]) begin mlk[k] = 0; mmiss[k] = 0; end
      else begin mmiss[k] = 1; tk = 1; end
    end else if (frame_sync) begin
      mse[k] = 1; mmiss[k] = 0; mpos[k] = 0; mval[k] = 0; tk = 1;
    end else tk = 1;
    if (tk) begin
      mval[k] = (mval[k] << 1) | longint'(din);
      mpos[k]++;
      if (mpos[k] == 4 * w) begin
        ma[k] = int'(mval[k] >> (3 * w)) & msk;
        mb[k] = int'(mval[k] >> (2 * w)) & msk;
        mc[k] = int'(mval[k] >> w) & msk;
        md[k] = int'(mval[k]) & msk;
        mfv[k] = 1; mpos[k] = 0; mval[k] = 0;
      end
    end
  endfunction

  always @(posedge clk) for (int k = 0; k < 2; k++) mstep(k);

  bit men = 0;
  always @(negedge clk) if (men) begin
    chk("m1.a", a1, ma[0]); chk("m1.b", b1, mb[0]); chk("m1.c", c1, mc[0]); chk("m1.d", d1, md[0]);
    chk("m1.slot", {s1_1, s0_1}, mlk[0] ? mpos[0] / mw[0] : 0);
    chk("m1.fv", fv1, mfv[0]); chk("m1.lock", lk1, mlk[0]); chk("m1.serr", se1, mse[0]);
    chk("m4.a", a4, ma[1]); chk("m4.b", b4, mb[1]); chk("m4.c", c4, mc[1]); chk("m4.d", d4, md[1]);
    chk("m4.slot", {s1_4, s0_4}, mlk[1] ? mpos[1] / mw[1] : 0);
    chk("m4.fv", fv4, mfv[1]); chk("m4.lock", lk4, mlk[1]); chk("m4.serr", se4, mse[1]);
  end

  task automatic beat(input bit v, input bit fs, input bit dd);
    in_valid = v; frame_sync = fs; din = dd;
    @(posedge clk); #1;
  endtask

  logic [15:0] fr;

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; men = 1;
    chk("t1 abcd", {a1, b1, c1, d1}, 0);
    chk("t1 lock", lk1, 0);
    chk("t1 fv", fv1, 0);
    chk("t1 slot", {s1_1, s0_1}, 0);
    rst = 1'b0;

    // SLOT_W=1 frame 1,0,1,1
    beat(1, 1, 1); chk("t2 lock", lk1, 1); chk("t2 slot1", {s1_1, s0_1}, 1);
    beat(1, 0, 0); chk("t2 slot2", {s1_1, s0_1}, 2);
    beat(1, 0, 1); chk("t2 slot3", {s1_1, s0_1}, 3); chk("t2 fv early", fv1, 0);
    beat(1, 0, 1); chk("t2 slot0", {s1_1, s0_1}, 0); chk("t2 fv", fv1, 1);
    chk("t2 abcd", {a1, b1, c1, d1}, 4'b1011);
    beat(0, 0, 0); chk("t2 fv pulse", fv1, 0); chk("t2 hold", {a1, b1, c1, d1}, 4'b1011);

    // SLOT_W=4 frame with in_valid toggling
    rst = 1'b1; beat(0, 0, 0); rst = 1'b0;
    fr = 16'b1010_0011_1111_0000;
    for (int i = 0; i < 16; i++) begin
      beat(1, i == 0, fr[15 - i]);
      if (i == 8) chk("t3 no partial", a4, 0);
      if (i < 15) beat(0, 0, 0);
    end
    chk("t3 a", a4, 4'hA); chk("t3 b", b4, 4'h3); chk("t3 c", c4, 4'hF); chk("t3 d", d4, 4'h0);
    chk("t3 fv", fv4, 1);
    beat(0, 0, 0); chk("t3 fv pulse", fv4, 0); chk("t3 hold", a4, 4'hA);

    // misaligned sync on beat 2
    beat(1, 1, 1); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 0);
    chk("t4 first frame", {a1, b1, c1, d1}, 4'b1100);
    beat(1, 1, 0); beat(1, 0, 1); beat(1, 1, 1);
    chk("t4 serr", se1, 1); chk("t4 no fv", fv1, 0); chk("t4 lock", lk1, 1);
    chk("t4 slot", {s1_1, s0_1}, 1); chk("t4 old abcd", {a1, b1, c1, d1}, 4'b1100);
    beat(1, 0, 0); chk("t4 serr pulse", se1, 0);
    beat(1, 0, 1); beat(1, 0, 1);
    chk("t4 fv", fv1, 1); chk("t4 abcd", {a1, b1, c1, d1}, 4'b1011);

    // flywheel then loss of lock
    beat(1, 0, 0); beat(1, 0, 1); beat(1, 0, 0); beat(1, 0, 1);
    chk("t5 fly fv", fv1, 1); chk("t5 fly abcd", {a1, b1, c1, d1}, 4'b0101); chk("t5 fly lock", lk1, 1);
    beat(1, 0, 1);
    chk("t5 unlock", lk1, 0); chk("t5 no fv", fv1, 0); chk("t5 slot", {s1_1, s0_1}, 0);
    chk("t5 hold", {a1, b1, c1, d1}, 4'b0101);
    beat(1, 1, 1); chk("t5 relock", lk1, 1);
    beat(1, 0, 1); beat(1, 0, 1); beat(1, 0, 0);
    chk("t5 fv", fv1, 1); chk("t5 abcd", {a1, b1, c1, d1}, 4'b1110);

    // reset mid-frame
    beat(1, 1, 1); beat(1, 0, 0); beat(1, 0, 1);
    rst = 1'b1; beat(1, 0, 1);
    chk("t6 abcd", {a1, b1, c1, d1}, 0); chk("t6 lock", lk1, 0); chk("t6 fv", fv1, 0);
    chk("t6 slot", {s1_1, s0_1}, 0); chk("t6 serr", se1, 0); chk("t6 a4", a4, 0);
    rst = 1'b0;
    beat(0, 0, 0); beat(0, 0, 0);
    chk("t6 still clear", {a1, b1, c1, d1}, 0);

    men = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tdm_demux_14.md
Name: tdm_demux_14

Overview:
- 1-to-4 time-division demultiplexer. Receiving end of the team's 4:1 mux datapath.
- Takes a serial stream of frames. Each frame holds four slots (a, b, c, d), sent in select order {s1,s0} = 00, 01, 10, 11.
- Collects each slot into a holding register, then presents all four slots as parallel outputs together with a one-cycle frame_valid strobe.
- Tracks frame alignment with a small HUNT/LOCK state machine driven by frame_sync.

Parameters:
- SLOT_W, 1, bits per slot; sent MSB first; legal range 1..16.
- FRAME_BEATS, 4*SLOT_W, derived: accepted beats per frame. Not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit
- in_valid  input  1  din is valid this cycle; counters advance only on accepted beats
- frame_sync  input  1  qualified by in_valid; marks beat 0 (MSB of slot a) of a frame
- a  output  SLOT_W  slot 0 ({s1,s0}=00), registered
- b  output  SLOT_W  slot 1 ({s1,s0}=01), registered
- c  output  SLOT_W  slot 2 ({s1,s0}=10), registered
- d  output  SLOT_W  slot 3 ({s1,s0}=11), registered
- s0  output  1  LSB of the slot index currently being filled
- s1  output  1  MSB of the slot index currently being filled
- frame_valid  output  1  one-cycle pulse; a..d hold a new complete frame
- locked  output  1  high in LOCK state
- sync_err  output  1  one-cycle pulse on a misaligned frame_sync

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - a, b, c, d = 0; s0 = s1 = 0; frame_valid = 0; locked = 0; sync_err = 0.
  - State = HUNT; bit counter = 0; shift/holding registers = 0.
- Reset overrides all other inputs. Reset mid-frame discards the partial frame; no frame_valid is issued for it.
- Accepted beat: in_valid = 1. When in_valid = 0, nothing changes except that the pulse outputs return to 0.
- Beat counter: 0..FRAME_BEATS-1.
  - Slot index {s1,s0} = beat / SLOT_W.
  - Bit-in-slot = beat % SLOT_W.
  - Each beat shifts left into the current slot's shift register (MSB first).
- HUNT state:
  - Beats without frame_sync are discarded; counter held at 0.
  - An accepted beat with frame_sync=1 moves to LOCK and takes din as beat 0; counter advances to 1.
- LOCK state:
  - Beats are accepted sequentially.
  - On the final beat (FRAME_BEATS-1), the holding registers plus that final bit are loaded into a..d on the same edge. frame_valid = 1 for exactly the following cycle. Counter wraps to 0.
  - Latency: a..d and frame_valid become visible 1 clk after the edge that accepts the last beat.
  - frame_sync is expected on beat 0 of every frame:
    - beat 0 without frame_sync: stay in LOCK (flywheel); no error.
    - frame_sync at beat != 0: sync_err pulses 1 cycle; the partial frame is discarded (no frame_valid); the frame restarts with this bit as beat 0; stay in LOCK.
  - Two consecutive beat-0s without frame_sync: return to HUNT, locked drops, and the current beat is discarded.
- Outputs a..d hold their last value between frames and are never partially updated.
- s1,s0 always reflect the slot of the next beat to be accepted. They read 00 in HUNT.
- SLOT_W = 1 case: one beat per slot. s1,s0 step 00→01→10→11 on consecutive accepted beats.

Decomposition:
- Package tdm_pkg:
  - state encoding localparams ST_HUNT = 1'b0, ST_LOCK = 1'b1.
  - slot index constants SLOT_A..SLOT_D = 2'b00..2'b11.
  - function clog2 for sizing the beat counter.
- One sub-module, tdm_slot_shreg: a SLOT_W-bit MSB-first shift register with load enable and clear. Instantiated four times, one per slot. The top level holds the FSM, the counter and the output registers.

Test Plan:
1. SLOT_W=1, rst high 2 cycles, then low → a=b=c=d=0, locked=0, frame_valid=0, {s1,s0}=00.
2. SLOT_W=1, frame_sync on beat 0, din=1,0,1,1 (in_valid=1) → locked=1 after first beat; {s1,s0} steps 01,10,11,00; 1 clk after 4th beat: a=1, b=0, c=1, d=1, frame_valid high for exactly 1 cycle.
3. SLOT_W=4, frame bits 1010_0011_1111_0000 with in_valid toggling 1/0 every cycle → a=4'hA, b=4'h3, c=4'hF, d=4'h0 after the 16th accepted beat; no output change on stalled cycles.
4. Locked, SLOT_W=1, frame_sync asserted on beat 2 → sync_err pulses once; no frame_valid for the partial frame; the next 4 beats (incl. this one) produce a correct frame.
5. Locked, two frames sent with no frame_sync → first frame completes normally (flywheel); at the following beat 0 without sync, locked=0 and the beat is discarded; the next frame_sync relocks.
6. rst asserted after beat 2 of a frame → outputs return to reset values; no frame_valid; the previously delivered a..d are cleared to 0.
